// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store and memory-write signal bundle for store_buffer; STORE_BUF_FWD_EN adds load-forwarding signals
interface store_buffer_if #(
    parameter int WIDTH = 32
);
    logic             st_valid;
    logic             st_ready;
    logic [WIDTH-1:0] st_addr;
    logic [WIDTH-1:0] st_data;
    logic [1:0]       st_size;
    logic             st_err;
    logic             mem_req;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             empty;
`ifdef STORE_BUF_FWD_EN
    logic [WIDTH-1:0] ld_addr;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [3:0]       fwd_be;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
        input  st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_be, empty,
               fwd_hit, fwd_data, fwd_be
    );
    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
        output st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_be, empty,
               fwd_hit, fwd_data, fwd_be
    );
`else
    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_be, empty
    );
    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_be, empty
    );
`endif
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer draining lane-shifted writes to memory
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
module store_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q;
    logic [WIDTH-3:0] ent_addr_q [DEPTH];
    logic [WIDTH-1:0] ent_data_q [DEPTH];
    logic [3:0]       ent_be_q   [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, nxt_ptr;
    logic [PW:0]      count_q;
    logic             mem_req_q, st_err_q;
    logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;
    logic [3:0]       mem_be_q;

    logic [1:0]       lo;
    logic             aligned, accept, push, pop, st_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_be;

    logic             load_en;
    logic [WIDTH-3:0] load_addr_d;
    logic [WIDTH-1:0] load_data_d;
    logic [3:0]       load_be_d;

    assign lo = bus.st_addr[1:0];

    // Format the incoming store into memory lanes and decide legality.
    always_comb begin
        aligned = 1'b0;
        in_data = '0;
        in_be   = 4'b0000;
        case (bus.st_size)
            2'b00: begin
                aligned = 1'b1;
                in_data = {{(WIDTH-8){1'b0}}, bus.st_data[7:0]} << {lo, 3'b000};
                in_be   = 4'b0001 << lo;
            end
            2'b01: begin
                aligned = ~lo[0];
                in_data = {{(WIDTH-16){1'b0}}, bus.st_data[15:0]} << {lo[1], 4'b0000};
                in_be   = 4'b0011 << {lo[1], 1'b0};
            end
            2'b10: begin
                aligned = (lo == 2'b00);
                in_data = bus.st_data;
                in_be   = 4'b1111;
            end
            default: ;
        endcase
    end

    // The entry being written to memory stays in the FIFO (and in count) until acked.
    assign pop      = (state_q == S_BUSY) && bus.mem_ack;
    assign st_ready = (count_q != CNT_FULL) || pop;
    assign accept   = bus.st_valid && st_ready && !rst;
    assign push     = accept && aligned;
    assign nxt_ptr  = rd_ptr_q + PTR_ONE;

    // Choose what the output registers take next: head, next entry, or a bypassed new store.
    always_comb begin
        load_en     = 1'b0;
        load_addr_d = ent_addr_q[rd_ptr_q];
        load_data_d = ent_data_q[rd_ptr_q];
        load_be_d   = ent_be_q[rd_ptr_q];
        if (state_q == S_IDLE) begin
            if (count_q != '0) begin
                load_en = 1'b1;
            end else if (push) begin
                load_en     = 1'b1;
                load_addr_d = bus.st_addr[WIDTH-1:2];
                load_data_d = in_data;
                load_be_d   = in_be;
            end
        end else if (pop) begin
            if (count_q > CNT_ONE) begin
                load_en     = 1'b1;
                load_addr_d = ent_addr_q[nxt_ptr];
                load_data_d = ent_data_q[nxt_ptr];
                load_be_d   = ent_be_q[nxt_ptr];
            end else if (push) begin
                load_en     = 1'b1;
                load_addr_d = bus.st_addr[WIDTH-1:2];
                load_data_d = in_data;
                load_be_d   = in_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= bus.st_addr[WIDTH-1:2];
            ent_data_q[wr_ptr_q] <= in_data;
            ent_be_q[wr_ptr_q]   <= in_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            st_err_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
        end else begin
            st_err_q <= accept && !aligned;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= nxt_ptr;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_q <= count_q - CNT_ONE;
            end
            if (load_en) begin
                state_q     <= S_BUSY;
                mem_req_q   <= 1'b1;
                mem_addr_q  <= {load_addr_d, 2'b00};
                mem_wdata_q <= load_data_d;
                mem_be_q    <= load_be_d;
            end else if (pop) begin
                state_q   <= S_IDLE;
                mem_req_q <= 1'b0;
            end
        end
    end

    assign bus.st_ready  = st_ready;
    assign bus.st_err    = st_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.empty     = (count_q == '0) && !mem_req_q;

`ifdef STORE_BUF_FWD_EN
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [3:0]       fwd_be;
    logic [PW-1:0]    fwd_idx;
    logic [1:0]       unused_ld_lo;

    assign unused_ld_lo = bus.ld_addr[1:0];

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_be   = 4'b0000;
        fwd_idx  = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (ent_addr_q[fwd_idx] == bus.ld_addr[WIDTH-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[fwd_idx];
                fwd_be   = ent_be_q[fwd_idx];
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit;
    assign bus.fwd_data = fwd_data;
    assign bus.fwd_be   = fwd_be;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer with a queue-based reference model
module tb_store_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.WIDTH(WIDTH)) bus();

    store_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = v;
        bus.st_size  = sz;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    // Reference: place each source byte into its memory lane; legal only if naturally aligned.
    function automatic logic ref_lane(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                      output wr_t w);
        int nbytes;
        int off;
        logic ok;
        off = int'(a[1:0]);
        case (sz)
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = 0;
        endcase
        ok = (nbytes != 0) && ((off % (nbytes == 0 ? 1 : nbytes)) == 0);
        w.addr = a & 32'hFFFF_FFFC;
        w.data = 32'h0;
        w.be   = 4'b0000;
        if (ok) begin
            for (int b = 0; b < nbytes; b++) begin
                w.be[off+b] = 1'b1;
                w.data[8*(off+b) +: 8] = d[8*b +: 8];
            end
        end
        return ok;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        drive_st(1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF);
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", bus.st_ready); end
        checks++; if (bus.st_err !== 1'b0) begin errors++; $display("FAIL reset_st_err got %b exp 0", bus.st_err); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
            errors++; $display("FAIL reset_mem_bus got %h %h %b exp 0", bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        checks++; if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_ignores_valid got empty %b req %b exp 1 0", bus.empty, bus.mem_req);
        end
    endtask

    task automatic test_byte_store();
        drive_st(1'b1, 2'd0, 32'h103, 32'hAB);
        #1;
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL sb_ready got %b exp 1", bus.st_ready); end
        tick();
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL sb_latency got %b exp 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr got %h exp 00000100", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata got %h exp ab000000", bus.mem_wdata); end
        checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", bus.mem_be); end
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
            errors++; $display("FAIL sb_hold got req %b addr %h exp 1 00000100", bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL sb_done got req %b empty %b exp 0 1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d [4];
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom();
            drive_st(1'b1, 2'd2, 32'h1000 + 32'(4*i), d[i]);
            tick();
        end
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.st_ready); end
        drive_st(1'b1, 2'd2, 32'h2000, 32'h5555_5555);
        tick();
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL ack_ready got %b exp 1", bus.st_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1000 + 32'(4*i) || bus.mem_wdata !== d[i]) begin
                errors++; $display("FAIL full_drain%0d got %b %h %h exp 1 %h %h", i, bus.mem_req, bus.mem_addr, bus.mem_wdata,
                                   32'h1000 + 32'(4*i), d[i]);
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL fifth_dropped got req %b empty %b exp 0 1", bus.mem_req, bus.empty);
        end
    endtask

    task automatic test_full_simul();
        logic [31:0] d [5];
        for (int i = 0; i < 5; i++) d[i] = $urandom();
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 2'd2, 32'h3000 + 32'(4*i), d[i]);
            tick();
        end
        drive_st(1'b1, 2'd2, 32'h3010, d[4]);
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b exp 1", bus.st_ready); end
        tick();
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL simul_still_full got %b exp 0", bus.st_ready); end
        bus.mem_ack = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h3000 + 32'(4*i) || bus.mem_wdata !== d[i]) begin
                errors++; $display("FAIL simul_order%0d got %b %h %h exp 1 %h %h", i, bus.mem_req, bus.mem_addr, bus.mem_wdata,
                                   32'h3000 + 32'(4*i), d[i]);
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz = '{2'd1, 2'd2, 2'd3};
        ad = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, sz[i], ad[i], 32'hCAFE_F00D);
            tick();
            drive_st(1'b0, 2'd0, 32'h0, 32'h0);
            checks++; if (bus.st_err !== 1'b1) begin errors++; $display("FAIL err_pulse%0d got %b exp 1", i, bus.st_err); end
            checks++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1) begin
                errors++; $display("FAIL err_dropped%0d got req %b empty %b exp 0 1", i, bus.mem_req, bus.empty);
            end
            tick();
            checks++; if (bus.st_err !== 1'b0) begin errors++; $display("FAIL err_once%0d got %b exp 0", i, bus.st_err); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_st(1'b1, 2'd2, 32'h4000 + 32'(4*i), $urandom());
            tick();
        end
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_before got %b exp 1", bus.mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1 || bus.st_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got req %b empty %b ready %b exp 0 1 1", bus.mem_req, bus.empty, bus.st_ready);
        end
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || bus.empty !== 1'b1 || bus.mem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_late_ack got req %b empty %b addr %h exp 0 1 0", bus.mem_req, bus.empty, bus.mem_addr);
        end
    endtask

    task automatic test_random();
        wr_t         exp_q [$];
        wr_t         w;
        logic        v, ack, ok, busy, pop, rdy, acc;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int cyc = 0; cyc < 420; cyc++) begin
            v   = (cyc < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            ack = (cyc < 400) ? ($urandom_range(0, 2) != 0) : 1'b1;
            sz  = 2'($urandom_range(0, 3));
            a   = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            drive_st(v, sz, a, $urandom());
            bus.mem_ack = ack;
            #1;
            busy = (exp_q.size() != 0);
            checks++; if (bus.mem_req !== busy) begin
                errors++; $display("FAIL rnd_req c%0d got %b exp %b", cyc, bus.mem_req, busy);
            end
            if (busy) begin
                checks++; if (bus.mem_addr !== exp_q[0].addr || bus.mem_wdata !== exp_q[0].data || bus.mem_be !== exp_q[0].be) begin
                    errors++; $display("FAIL rnd_head c%0d got %h %h %b exp %h %h %b", cyc, bus.mem_addr, bus.mem_wdata,
                                       bus.mem_be, exp_q[0].addr, exp_q[0].data, exp_q[0].be);
                end
            end
            pop = busy && ack;
            rdy = (exp_q.size() < DEPTH) || pop;
            checks++; if (bus.st_ready !== rdy) begin
                errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, bus.st_ready, rdy);
            end
            acc = v && rdy;
            ok  = ref_lane(sz, a, bus.st_data, w);
            tick();
            if (pop) void'(exp_q.pop_front());
            if (acc && ok) exp_q.push_back(w);
            checks++; if (bus.st_err !== (acc && !ok)) begin
                errors++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, bus.st_err, acc && !ok);
            end
            checks++; if (bus.empty !== (exp_q.size() == 0)) begin
                errors++; $display("FAIL rnd_empty c%0d got %b exp %b", cyc, bus.empty, exp_q.size() == 0);
            end
        end
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        bus.mem_ack = 1'b0;
        checks++; if (exp_q.size() != 0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL rnd_drained got left %0d empty %b exp 0 1", exp_q.size(), bus.empty);
        end
    endtask

`ifdef STORE_BUF_FWD_EN
    task automatic test_forward();
        drive_st(1'b1, 2'd2, 32'h200, 32'h1111_1111);
        tick();
        drive_st(1'b1, 2'd0, 32'h201, 32'h22);
        tick();
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
        bus.ld_addr = 32'h200;
        #1;
        checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h0000_2200 || bus.fwd_be !== 4'b0010) begin
            errors++; $display("FAIL fwd_young got %b %h %b exp 1 00002200 0010", bus.fwd_hit, bus.fwd_data, bus.fwd_be);
        end
        bus.ld_addr = 32'h204;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0 || bus.fwd_be !== 4'b0000) begin
            errors++; $display("FAIL fwd_miss got %b %h %b exp 0 0 0000", bus.fwd_hit, bus.fwd_data, bus.fwd_be);
        end
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        bus.ld_addr = 32'h203;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL fwd_drained got hit %b empty %b exp 0 1", bus.fwd_hit, bus.empty);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.mem_ack = 1'b0;
        drive_st(1'b0, 2'd0, 32'h0, 32'h0);
`ifdef STORE_BUF_FWD_EN
        bus.ld_addr = 32'h0;
`endif
        test_reset();
        test_byte_store();
        test_backpressure();
        test_full_simul();
        test_misaligned();
        test_reset_mid();
        test_random();
`ifdef STORE_BUF_FWD_EN
        test_forward();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 st_valid  input  1  core presents a store.
REQ-006 st_ready  output  1  buffer can accept a store; high when not full.
REQ-007 st_addr  input  WIDTH  byte address of the store.
REQ-008 st_data  input  WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 st_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 st_err  output  1  one-cycle pulse flagging a dropped misaligned or reserved-size store.
REQ-011 mem_req  output  1  write request to data memory.
REQ-012 mem_ack  input  1  memory accepted the current write.
REQ-013 mem_addr  output  WIDTH  word-aligned write address, with [1:0] = 00.
REQ-014 mem_wdata  output  WIDTH  lane-shifted write data.
REQ-015 mem_be  output  4  byte enables.
REQ-016 empty  output  1  no entries held and no write outstanding.

Function
REQ-017 A store is accepted when st_valid and st_ready are both high at a clock edge.
REQ-018 Lane placement: byte -> data shifted by 8*addr[1:0], be = 0001 << addr[1:0]; half -> shifted by 16*addr[1], be = 0011 << 2*addr[1]; word -> be = 1111.
REQ-019 Misaligned stores (half with addr[0]=1, word with addr[1:0]!=00) and size 11 are not enqueued.
REQ-020 For such a dropped store, st_err pulses high in the cycle after the handshake.
REQ-021 The buffer is a FIFO with read/write pointers that wrap modulo DEPTH, plus an occupancy count of 0..DEPTH.
REQ-022 Drain FSM, IDLE state: when the FIFO is non-empty, load the head entry into the output registers, assert mem_req and go to BUSY.
REQ-023 Drain FSM, BUSY state: hold mem_req, mem_addr, mem_wdata and mem_be stable until mem_ack.
REQ-024 On mem_ack in BUSY, pop the head; if another entry exists, present it the next cycle (back-to-back) and stay in BUSY; otherwise go to IDLE and deassert mem_req.
REQ-025 Latency: a store accepted into an empty buffer drives mem_req in the next cycle.
REQ-026 Enqueue and pop in the same cycle leave the count unchanged; both proceed when the buffer is full.
REQ-027 st_ready is driven combinationally from count != DEPTH or (count == DEPTH and a pop occurs this cycle).
REQ-028 mem_ack while mem_req is low is ignored.
REQ-029 Stores drain strictly in acceptance order; no merging or coalescing.

Reset
REQ-030 Reset values: count = 0; pointers = 0; FSM = IDLE; mem_req = 0; st_err = 0; mem_addr, mem_wdata, mem_be = 0; st_ready = 1; empty = 1.
REQ-031 Reset asserted mid-transfer discards all entries and the outstanding request without waiting for mem_ack.
REQ-032 While rst is high, st_valid is ignored.

Configuration
REQ-033 Macro STORE_BUF_FWD_EN, when defined, adds ports ld_addr (input, WIDTH), fwd_hit (output, 1), fwd_data (output, WIDTH) and fwd_be (output, 4).
REQ-034 With STORE_BUF_FWD_EN defined, fwd_hit is combinational.
REQ-035 fwd_hit is high when any held entry (including the one in BUSY) has word address equal to ld_addr[WIDTH-1:2].
REQ-036 On a hit, fwd_data and fwd_be come from the youngest matching entry; on a miss both are zero.
REQ-037 Without STORE_BUF_FWD_EN, these ports and their logic are absent.

Verification
REQ-038 SB at addr 0x103, data 0xAB -> mem_addr 0x100, mem_wdata 0xAB000000, mem_be 1000; mem_req is high the cycle after acceptance.
REQ-039 Four SW stores with mem_ack held low -> st_ready low after the 4th; a 5th st_valid is not accepted; first mem_ack -> st_ready high the same cycle.
REQ-040 Fill to full, then assert st_valid and mem_ack together -> store accepted, count stays 4, write order preserved.
REQ-041 SH at 0x101 -> st_err pulses once, no mem_req, empty stays 1; SW at 0x102 behaves the same.
REQ-042 Assert rst while mem_req is high with 3 entries held -> next cycle mem_req 0, empty 1, st_ready 1; a later mem_ack has no effect.
REQ-043 With STORE_BUF_FWD_EN: SW 0x11111111 then SB 0x22 at 0x201, with ld_addr 0x200 -> fwd_hit 1, fwd_data 0x00002200, fwd_be 0010.
